// File: rtl/mult_seq_ctrl_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | mult_seq_ctrl_if                                                     |
// | Request, response and datapath signals of the multiplier sequencer. |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
interface mult_seq_ctrl_if #(
   parameter int TAG_W = 5
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [31:0]      req_rs1;
   logic [31:0]      req_rs2;
   logic [TAG_W-1:0] req_tag;
   logic             flush;
   logic             dp_enable;
   logic [32:0]      dp_a;
   logic [32:0]      dp_b;
   logic [63:0]      dp_product;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   logic [TAG_W-1:0] rsp_tag;
   logic             busy;

   // controller side
   modport slave (
      input  req_valid, req_op, req_rs1, req_rs2, req_tag, flush, dp_product, rsp_ready,
      output req_ready, dp_enable, dp_a, dp_b, rsp_valid, rsp_data, rsp_tag, busy
   );

   // execute stage / multiplier side
   modport master (
      output req_valid, req_op, req_rs1, req_rs2, req_tag, flush, dp_product, rsp_ready,
      input  req_ready, dp_enable, dp_a, dp_b, rsp_valid, rsp_data, rsp_tag, busy
   );
endinterface
`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | mult_seq_ctrl                                                        |
// | RV32M multiply sequencer; MULT_RESULT_CACHE_EN adds a result cache. |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
module mult_seq_ctrl #(
   parameter int MUL_LATENCY = 2,
   parameter int TAG_W       = 5
) (
   input wire             clk,
   input wire             rst_n,
   mult_seq_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] C_CNT_LOAD = 4'(MUL_LATENCY - 1);
   localparam logic [1:0] C_OP_MUL   = 2'b00;
   localparam logic [1:0] C_OP_MULHU = 2'b11;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_cnt;
   logic [1:0]       r_op;
   logic [TAG_W-1:0] r_tag;
   logic [32:0]      r_dp_a;
   logic [32:0]      r_dp_b;
   logic [31:0]      r_rsp_data;
   logic             r_hit;
   logic             w_req_ready;
   logic             w_accept;
   logic             w_capture;
   logic             w_hit;
   logic [31:0]      w_hit_data;
   logic [32:0]      w_a_ext;
   logic [32:0]      w_b_ext;
   logic [31:0]      w_product_sel;

   assign w_req_ready = !bus.flush && (r_state == S_IDLE || (r_state == S_DONE && bus.rsp_ready));
   assign w_accept    = bus.req_valid && w_req_ready;
   assign w_capture   = (r_state == S_BUSY) && (r_cnt == 4'd0) && !bus.flush;

   // rs1 is signed except for MULHU; rs2 is signed only for MUL/MULH
   assign w_a_ext = {(bus.req_op != C_OP_MULHU) & bus.req_rs1[31], bus.req_rs1};
   assign w_b_ext = {!bus.req_op[1] & bus.req_rs2[31], bus.req_rs2};

   assign w_product_sel = (r_op == C_OP_MUL) ? bus.dp_product[31:0] : bus.dp_product[63:32];

`ifdef MULT_RESULT_CACHE_EN
   logic        r_c_valid;
   logic [1:0]  r_c_op;
   logic [31:0] r_c_rs1;
   logic [31:0] r_c_rs2;
   logic [31:0] r_c_result;

   assign w_hit = r_c_valid && (r_c_op == bus.req_op) &&
                  (r_c_rs1 == bus.req_rs1) && (r_c_rs2 == bus.req_rs2);
   assign w_hit_data = r_c_result;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_c_valid  <= 1'b0;
         r_c_op     <= 2'b00;
         r_c_rs1    <= 32'd0;
         r_c_rs2    <= 32'd0;
         r_c_result <= 32'd0;
      end else if (w_capture && !r_hit) begin
         r_c_valid  <= 1'b1;
         r_c_op     <= r_op;
         r_c_rs1    <= r_dp_a[31:0];
         r_c_rs2    <= r_dp_b[31:0];
         r_c_result <= w_product_sel;
      end
   end
`else
   assign w_hit      = 1'b0;
   assign w_hit_data = 32'd0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_BUSY;
         S_BUSY: if (r_cnt == 4'd0) w_state_nxt = S_DONE;
         S_DONE: if (bus.rsp_ready) w_state_nxt = w_accept ? S_BUSY : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (bus.flush) w_state_nxt = S_IDLE;
   end

   // a cache hit spends one BUSY cycle with the datapath idle, then returns the cached value
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_op       <= 2'b00;
         r_tag      <= '0;
         r_dp_a     <= 33'd0;
         r_dp_b     <= 33'd0;
         r_rsp_data <= 32'd0;
         r_hit      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op   <= bus.req_op;
            r_tag  <= bus.req_tag;
            r_dp_a <= w_a_ext;
            r_dp_b <= w_b_ext;
            r_hit  <= w_hit;
            r_cnt  <= w_hit ? 4'd0 : C_CNT_LOAD;
         end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_capture) r_rsp_data <= r_hit ? w_hit_data : w_product_sel;
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.dp_enable = (r_state == S_BUSY) && !r_hit;
   assign bus.dp_a      = r_dp_a;
   assign bus.dp_b      = r_dp_b;
   assign bus.rsp_valid = (r_state == S_DONE);
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_tag   = r_tag;
   assign bus.busy      = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequencing controller for the RV32M Booth radix-8 multiplier datapath. It sits between the execute stage and the multiplier. It accepts one MUL/MULH/MULHSU/MULHU request at a time over a valid/ready handshake, formats the 33-bit signed operands, and holds the datapath enable for a fixed latency. It then captures the 64-bit product, selects the architectural 32-bit half, and returns it with its tag over a second valid/ready handshake, with pipeline flush support.

## Interface
- `MUL_LATENCY`, default 2: datapath cycles from enable to valid product; legal range 1..15.
- `TAG_W`, default 5: width of the request tag (destination register index).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept this cycle.
- `req_op`  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `req_rs1`, `req_rs2`  in  32  operands.
- `req_tag`  in  `TAG_W`  returned unchanged with the result.
- `flush`  in  1  kill any in-flight or pending operation.
- `dp_enable`  out  1  multiplier datapath enable.
- `dp_a`, `dp_b`  out  33  signed operands to the datapath.
- `dp_product`  in  64  low 64 bits of `dp_a*dp_b`; valid after `MUL_LATENCY` enabled cycles.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  32  selected result half.
- `rsp_tag`  out  `TAG_W`  tag of the result.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **States.**
  - IDLE: waiting for a request.
  - BUSY: the datapath is computing.
  - DONE: the result is held.
- **Acceptance.** A request is accepted when `req_valid && req_ready`.
  - `req_ready` = `!flush && (IDLE || (DONE && rsp_ready))`.
  - This allows back-to-back accept in the same cycle as a response handshake.
- **On accept:** latch op, tag, `dp_a` and `dp_b`, load the counter with `MUL_LATENCY-1`, and go to BUSY.
- **Operand extension into `dp_a`/`dp_b`:**
  - MUL, MULH: both operands sign-extended.
  - MULHSU: rs1 sign-extended, rs2 zero-extended.
  - MULHU: both operands zero-extended.
- **BUSY.**
  - `dp_enable` = 1, and `dp_a`/`dp_b` are held stable.
  - The counter decrements each cycle.
  - At the edge where the counter is 0: capture `rsp_data` and go to DONE.
  - The captured value is `dp_product[31:0]` for MUL and `dp_product[63:32]` otherwise.
- **DONE.**
  - `rsp_valid` = 1; `rsp_data` and `rsp_tag` are held until `rsp_ready`.
  - On handshake: go to BUSY if a new request is accepted in the same cycle, else go to IDLE.
- **Flush.** Has priority over everything; at the next edge the state becomes IDLE.
  - `rsp_valid` drops and no response is issued for the killed operation.
  - `flush` together with `req_valid` means no accept.
- **Idle outputs.** `dp_enable` = 0 outside BUSY; `dp_a`/`dp_b` keep their last latched value.

## Timing
- **Reset values:** state IDLE, `req_ready` 1 (if `flush` low), `dp_enable` 0, `dp_a`/`dp_b` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_tag` 0, `busy` 0, counter 0.
- **Reset mid-operation:** abandons the operation with no response, identical to the reset values above.
- **Latency.** Accept at edge E0 → `dp_enable` high for cycles E0..E0+`MUL_LATENCY` → `rsp_valid` high from E0+`MUL_LATENCY`.
- **Throughput:** one result per `MUL_LATENCY`+1 cycles with `rsp_ready` tied high.
- **`rsp_valid` is never dropped without a handshake, except by flush or reset.**

## Configuration
- Macro: `MULT_RESULT_CACHE_EN`.
- **Defined:** a one-entry cache holds {valid, op, rs1, rs2, result}.
  - **Fill:** written at each BUSY→DONE capture.
  - **Hit:** an accepted request whose op, rs1 and rs2 all match a valid entry goes straight to DONE with the cached result.
    - `rsp_valid` rises at E0+1.
    - `dp_enable` is not asserted.
  - **Invalidation:** cleared by reset only.
  - **Flushed operations:** never fill the cache.
- **Undefined:** no cache logic; every request goes through BUSY.

## Test plan
- Reset with `rst_n`=0 for 2 cycles → every output at its reset value, `req_ready`=1.
- MULH rs1=0xFFFFFFFE (−2), rs2=3, `MUL_LATENCY`=2, accept at E0 → `rsp_data`=0xFFFFFFFF with the tag, `rsp_valid` at E0+2, `dp_enable` high for exactly 2 cycles.
- MULHU and MUL with 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE and 0x00000001 respectively. MULHSU with 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- `rsp_ready` held 0 for 5 cycles in DONE → `rsp_data`/`rsp_tag` stable and `req_ready`=0. Release with `req_valid`=1 → back-to-back accept, `busy` stays 1.
- `flush` during BUSY cycle 1 → IDLE next edge, no `rsp_valid`, next request completes normally. `flush` with `req_valid`=1 → no accept.
- With `MULT_RESULT_CACHE_EN`: repeat an identical MUL 7×6 → second response 42 at E0+1 with no `dp_enable`. Changing rs2 → full-latency path.
